// File: rtl/uram_event_writer_if.sv
// rtl/uram_event_writer_if.sv - URAM write bus and event descriptor handshake
// master = writer side, slave = URAM/readout side.
interface uram_event_writer_if #(
  parameter int ADDR_BITS = 12,
  parameter int DW        = 72
);
  logic                 uram_we_o;
  logic [ADDR_BITS-1:0] uram_addr_o;
  logic [DW-1:0]        uram_dat_o;
  logic [ADDR_BITS-1:0] evt_addr_o;
  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic                 evt_done_i;

  modport master (
    output uram_we_o, uram_addr_o, uram_dat_o, evt_addr_o, evt_valid_o,
    input  evt_ready_i, evt_done_i
  );

  modport slave (
    input  uram_we_o, uram_addr_o, uram_dat_o, evt_addr_o, evt_valid_o,
    output evt_ready_i, evt_done_i
  );
endinterface

// File: rtl/uram_event_writer.sv
// rtl/uram_event_writer.sv - circular URAM ring writer turning triggers into event descriptors
// Optional dropped-trigger counter is built when URAM_WRITER_DROPCNT_EN is defined.
module uram_event_writer #(
  parameter int  NBIT      = 12,
  parameter int  NSAMP_MEM = 6,
  parameter int  ADDR_BITS = 12,
  parameter int  PRETRIG   = 64,
  parameter int  POSTTRIG  = 192,
  parameter int  MAX_PEND  = 4,
  localparam int DW        = NBIT * NSAMP_MEM,
  localparam int PW        = $clog2(MAX_PEND + 1)
) (
  input  logic                memclk_i,
  input  logic                memclk_rstn_i,
  input  logic                memclk_sync_i,
  input  logic [DW-1:0]       dat_i,
  input  logic                run_i,
  input  logic                trig_i,
  uram_event_writer_if.master bus,
  output logic [PW-1:0]       pending_o,
  output logic                sync_err_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int CW = $clog2(POSTTRIG + 1);
  localparam logic [CW-1:0]        POST_LD  = CW'(POSTTRIG);
  localparam logic [ADDR_BITS-1:0] PRE_OFS  = ADDR_BITS'(PRETRIG);
  localparam logic [PW-1:0]        PEND_MAX = PW'(MAX_PEND);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_RUN       = 2'd2,
    S_POST      = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] start_q, start_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [ADDR_BITS-1:0] evt_addr_q, evt_addr_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic                 sync_err_q, sync_err_d;

  logic                 in_write_state;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 abandon;
  logic                 done_eff;
  logic                 pend_full;
  logic                 trig_accept;
  logic                 evt_load;

  assign in_write_state = (state_q == S_RUN) || (state_q == S_POST);
  assign wr_en          = in_write_state || ((state_q == S_WAIT_SYNC) && memclk_sync_i);
  // The sync cycle itself writes address 0 so the ring stays aligned to the 4-word group.
  assign wr_addr        = (state_q == S_WAIT_SYNC) ? '0 : ptr_q;
  assign abandon        = (state_q == S_POST) && !run_i;
  // A release must never take the count below zero, including the abandoned slot.
  assign done_eff       = bus.evt_done_i &&
                          (abandon ? (pending_q > PW'(1)) : (pending_q != '0));
  assign pend_full      = (pending_q == PEND_MAX);
  // A slot freed in the same cycle makes room for the incoming trigger.
  assign trig_accept    = (state_q == S_RUN) && run_i && trig_i && (!pend_full || done_eff);
  assign evt_load       = (state_q == S_POST) && run_i && (cnt_q == '0) &&
                          (!evt_valid_q || bus.evt_ready_i);

  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!run_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_WAIT_SYNC;
        S_WAIT_SYNC: if (memclk_sync_i) state_d = S_RUN;
        S_RUN:       if (trig_accept) state_d = S_POST;
        S_POST:      if (evt_load) state_d = S_RUN;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    we_d    = wr_en;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    ptr_d   = ptr_q;
    if (wr_en) begin
      waddr_d = wr_addr;
      wdat_d  = dat_i;
      ptr_d   = wr_addr + ADDR_BITS'(1);
    end

    cnt_d   = cnt_q;
    start_d = start_q;
    if (trig_accept) begin
      cnt_d   = POST_LD;
      start_d = {ptr_q[ADDR_BITS-1:2], 2'b00} - PRE_OFS;
    end else if ((state_q == S_POST) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    evt_valid_d = evt_valid_q;
    evt_addr_d  = evt_addr_q;
    if (evt_load) begin
      evt_valid_d = 1'b1;
      evt_addr_d  = start_q;
    end else if (evt_valid_q && bus.evt_ready_i) begin
      evt_valid_d = 1'b0;
    end

    pending_d = pending_q + PW'(trig_accept) - PW'(done_eff) - PW'(abandon);

    sync_err_d = sync_err_q;
    if (state_d == S_IDLE) begin
      sync_err_d = 1'b0;
    end else if (memclk_sync_i && in_write_state && (ptr_q[1:0] != 2'b00)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      ptr_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdat_q      <= '0;
      cnt_q       <= '0;
      start_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_addr_q  <= '0;
      pending_q   <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdat_q      <= wdat_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      evt_valid_q <= evt_valid_d;
      evt_addr_q  <= evt_addr_d;
      pending_q   <= pending_d;
      sync_err_q  <= sync_err_d;
    end
  end

`ifdef URAM_WRITER_DROPCNT_EN
  logic        trig_drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign trig_drop = trig_i && (!run_i || (state_q == S_POST) ||
                                ((state_q == S_RUN) && !trig_accept));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (trig_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign bus.uram_we_o   = we_q;
  assign bus.uram_addr_o = waddr_q;
  assign bus.uram_dat_o  = wdat_q;
  assign bus.evt_valid_o = evt_valid_q;
  assign bus.evt_addr_o  = evt_addr_q;
  assign pending_o       = pending_q;
  assign sync_err_o      = sync_err_q;

endmodule
